// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the external SRAM arbiter: config register address,
// access FSM states and grant sources.
package llander_sram_pkg;

  localparam logic [18:0] CFG_ADDR = 19'h08FD5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  typedef enum logic [1:0] {
    SRC_CFG,
    SRC_A,
    SRC_B
  } src_t;

endpackage

// File: rtl/sram_arbiter.sv
// Shares one async 8-bit SRAM between video reads (A), frame/vector accesses (B)
// and a periodic SCANDBLCTRL poller; every access returns to IDLE for one turnaround cycle.
module sram_arbiter
  import llander_sram_pkg::*;
#(
  parameter int ACC_CYCLES = 3,
  parameter int WE_CYCLES  = 2,
  parameter int CFG_PERIOD = 65536,
  parameter int B_MAX_WAIT = 4
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        a_req,
  input  logic [18:0] a_addr,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [18:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_oe,
  input  logic [7:0]  sram_din,
  output logic        sram_we,
  output logic [1:0]  scandblctrl,
  output logic        cfg_valid
);

  localparam int PHASE_MAX = (ACC_CYCLES > WE_CYCLES) ? ACC_CYCLES : WE_CYCLES;
  localparam int PW = $clog2(PHASE_MAX);
  localparam int TW = $clog2(CFG_PERIOD);
  localparam int WW = $clog2(B_MAX_WAIT + 1);

  localparam logic [PW-1:0] ACC_LAST = PW'(ACC_CYCLES - 1);
  localparam logic [PW-1:0] WE_LAST  = PW'(WE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(CFG_PERIOD - 1);
  localparam logic [WW-1:0] W_MAX    = WW'(B_MAX_WAIT);

  state_t        state;
  src_t          src;
  logic [PW-1:0] phase;
  logic [TW-1:0] timer;
  logic          cfg_pend;
  logic [WW-1:0] wait_cnt;

  logic b_forced;
  logic grant_a;
  logic grant_b;

  // Priority: pending poll, then starved B, then A, then B.
  always_comb begin
    b_forced = b_req && (wait_cnt == W_MAX);
    grant_a  = !cfg_pend && !b_forced && a_req;
    grant_b  = !cfg_pend && (b_forced || (!a_req && b_req));
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state       <= IDLE;
      src         <= SRC_CFG;
      phase       <= '0;
      timer       <= '0;
      cfg_pend    <= 1'b0;
      wait_cnt    <= '0;
      sram_addr   <= '0;
      sram_dout   <= '0;
      sram_oe     <= 1'b0;
      sram_we     <= 1'b0;
      a_ack       <= 1'b0;
      a_rdata     <= '0;
      b_ack       <= 1'b0;
      b_rdata     <= '0;
      scandblctrl <= 2'b00;
      cfg_valid   <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      if (timer == T_LAST) begin
        timer    <= '0;
        cfg_pend <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end

      // Grant clear below must override a same-edge wrap, hence its placement after the timer.
      case (state)
        IDLE: begin
          phase <= '0;
          if (cfg_pend) begin
            cfg_pend  <= 1'b0;
            src       <= SRC_CFG;
            sram_addr <= CFG_ADDR;
            state     <= READ;
          end else if (grant_a) begin
            src       <= SRC_A;
            sram_addr <= a_addr;
            state     <= READ;
            if (b_req && (wait_cnt != W_MAX)) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else if (grant_b) begin
            src       <= SRC_B;
            sram_addr <= b_addr;
            wait_cnt  <= '0;
            if (b_we) begin
              sram_dout <= b_wdata;
              sram_oe   <= 1'b1;
              state     <= WR_SETUP;
            end else begin
              state <= READ;
            end
          end
        end

        READ: begin
          if (phase == ACC_LAST) begin
            state <= IDLE;
            case (src)
              SRC_CFG: begin
                scandblctrl <= sram_din[1:0];
                cfg_valid   <= 1'b1;
              end
              SRC_A: begin
                a_rdata <= sram_din;
                a_ack   <= 1'b1;
              end
              SRC_B: begin
                b_rdata <= sram_din;
                b_ack   <= 1'b1;
              end
              default: ;
            endcase
          end else begin
            phase <= phase + 1'b1;
          end
        end

        WR_SETUP: begin
          sram_we <= 1'b1;
          phase   <= '0;
          state   <= WR_PULSE;
        end

        WR_PULSE: begin
          if (phase == WE_LAST) begin
            sram_we <= 1'b0;
            b_ack   <= 1'b1;
            state   <= WR_HOLD;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        WR_HOLD: begin
          sram_oe <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          sram_we <= 1'b0;
          sram_oe <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, polling, A/B access timing, fairness,
// poll priority and reset during a write pulse, against a behavioural SRAM.
module tb_sram_arbiter;

  localparam int ACC = 3;
  localparam int WEC = 2;
  localparam int P   = 128;
  localparam int BMW = 4;
  localparam logic [18:0] CFG = 19'h08FD5;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        a_req;
  logic [18:0] a_addr;
  logic        a_ack;
  logic [7:0]  a_rdata;
  logic        b_req;
  logic        b_we;
  logic [18:0] b_addr;
  logic [7:0]  b_wdata;
  logic        b_ack;
  logic [7:0]  b_rdata;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_oe;
  logic [7:0]  sram_din;
  logic        sram_we;
  logic [1:0]  scandblctrl;
  logic        cfg_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] mem [0:524287];
  logic [7:0] cfg_byte = 8'h02;

  always #5 clk50 = ~clk50;

  sram_arbiter #(
    .ACC_CYCLES(ACC),
    .WE_CYCLES (WEC),
    .CFG_PERIOD(P),
    .B_MAX_WAIT(BMW)
  ) dut (
    .clk50      (clk50),
    .reset      (reset),
    .a_req      (a_req),
    .a_addr     (a_addr),
    .a_ack      (a_ack),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_ack      (b_ack),
    .b_rdata    (b_rdata),
    .sram_addr  (sram_addr),
    .sram_dout  (sram_dout),
    .sram_oe    (sram_oe),
    .sram_din   (sram_din),
    .sram_we    (sram_we),
    .scandblctrl(scandblctrl),
    .cfg_valid  (cfg_valid)
  );

  // Async SRAM: two preloaded cells, everything else comes from writes.
  assign sram_din = (sram_addr == CFG)        ? cfg_byte :
                    (sram_addr == 19'h01234)  ? 8'hA5    : mem[sram_addr];

  always @(posedge clk50) begin
    if (sram_we) mem[sram_addr] <= sram_dout;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
    cyc++;
  endtask

  task automatic wait_phase(input int ph);
    do tick(); while ((cyc % P) != ph);
  endtask

  task automatic a_read(input logic [18:0] addr, output logic [7:0] data, output int lat);
    a_addr = addr;
    a_req  = 1'b1;
    lat    = 0;
    do begin
      tick();
      lat++;
    end while (!a_ack && lat < 40);
    a_req = 1'b0;
    data  = a_rdata;
  endtask

  task automatic b_access(input logic we, input logic [18:0] addr, input logic [7:0] wdata,
                          output logic [7:0] rdata, output int lat, output int we_c,
                          output int oe_c, output int stable);
    b_we    = we;
    b_addr  = addr;
    b_wdata = wdata;
    b_req   = 1'b1;
    lat = 0; we_c = 0; oe_c = 0; stable = 1;
    do begin
      tick();
      lat++;
      if (sram_we) we_c++;
      if (sram_oe) begin
        oe_c++;
        if (sram_addr != addr || sram_dout != wdata) stable = 0;
      end
    end while (!b_ack && lat < 40);
    b_req = 1'b0;
    rdata = b_rdata;
  endtask

  initial begin
    logic [7:0] d;
    int lat, lat2, we_c, oe_c, stable, acnt, nb, both;
    int runs [2];

    reset = 1'b1; a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = 1'b0;
    b_addr = '0; b_wdata = '0;
    repeat (5) tick();
    check("rst_we",      32'(sram_we), 0);
    check("rst_oe",      32'(sram_oe), 0);
    check("rst_addr",    32'(sram_addr), 0);
    check("rst_acks",    32'({a_ack, b_ack}), 0);
    check("rst_scandbl", 32'(scandblctrl), 0);
    check("rst_cfgv",    32'(cfg_valid), 0);
    reset = 1'b0;
    cyc   = 0;

    // First poll: wrap at edge P, grant at P+1, data at P+ACC+1.
    while (!cfg_valid && cyc < 300) tick();
    check("poll1_cycle",  cyc, P + ACC + 1);
    check("poll1_scandbl", 32'(scandblctrl), 32'h2);

    wait_phase(10);
    a_read(19'h01234, d, lat);
    check("a_lat",   lat, ACC + 1);
    check("a_rdata", 32'(d), 32'hA5);
    tick();
    check("a_ack_pulse", 32'(a_ack), 0);
    check("a_rdata_hold", 32'(a_rdata), 32'hA5);

    b_access(1'b1, 19'h04000, 8'h3C, d, lat, we_c, oe_c, stable);
    check("bw_lat",    lat, WEC + 2);
    check("bw_we_cyc", we_c, WEC);
    check("bw_oe_cyc", oe_c, WEC + 2);
    check("bw_stable", stable, 1);
    tick();
    check("bw_turn_oe", 32'(sram_oe), 0);

    a_read(19'h04000, d, lat);
    check("rb_lat",   lat, ACC + 1);
    check("rb_rdata", 32'(d), 32'h3C);

    b_access(1'b0, 19'h01234, 8'h00, d, lat, we_c, oe_c, stable);
    check("br_lat",   lat, ACC + 1);
    check("br_rdata", 32'(d), 32'hA5);
    check("br_we",    we_c, 0);

    // Both ports held: B is forced after BMW A grants, pattern repeats.
    wait_phase(40);
    a_addr = 19'h01234; a_req = 1'b1;
    b_addr = 19'h05000; b_wdata = 8'h77; b_we = 1'b1; b_req = 1'b1;
    acnt = 0; nb = 0; both = 0; runs[0] = -1; runs[1] = -1;
    for (int i = 0; i < 80 && nb < 2; i++) begin
      tick();
      if (a_ack && b_ack) both++;
      if (a_ack) acnt++;
      if (b_ack) begin
        runs[nb] = acnt;
        nb++;
        acnt = 0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("fair_nb",   nb, 2);
    check("fair_run0", runs[0], BMW);
    check("fair_run1", runs[1], BMW);
    check("fair_both", both, 0);

    // Timer wraps during an A read: poll wins over re-requesting A and pending B.
    cfg_byte = 8'h01;
    wait_phase(P - 2);
    b_we = 1'b0; b_addr = 19'h01234; b_req = 1'b1;
    a_addr = 19'h01234; a_req = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!a_ack && lat < 40);
    check("wrap_a1_lat", lat, ACC + 1);
    a_addr = 19'h04000;
    tick();
    check("wrap_poll_addr", 32'(sram_addr), 32'(CFG));
    lat2 = 0;
    do begin tick(); lat2++; end while (!a_ack && lat2 < 40);
    a_req = 1'b0;
    check("wrap_a2_lat",  lat2, 2 * (ACC + 1) - 1);
    check("wrap_a2_data", 32'(a_rdata), 32'h3C);
    check("wrap_scandbl", 32'(scandblctrl), 32'h1);
    lat = 0;
    do begin tick(); lat++; end while (!b_ack && lat < 40);
    b_req = 1'b0;
    check("wrap_b_lat",  lat, ACC + 1);
    check("wrap_b_data", 32'(b_rdata), 32'hA5);

    // Reset in the middle of the write pulse.
    wait_phase(20);
    b_we = 1'b1; b_addr = 19'h06000; b_wdata = 8'h5A; b_req = 1'b1;
    tick(); tick();
    check("rw_in_pulse", 32'(sram_we), 1);
    reset = 1'b1; b_req = 1'b0;
    tick();
    check("rw_we",  32'(sram_we), 0);
    check("rw_oe",  32'(sram_oe), 0);
    check("rw_ack", 32'(b_ack), 0);
    reset = 1'b0;
    cyc   = 0;
    acnt  = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_ack || b_ack || sram_oe) acnt++;
    end
    check("rw_no_ack", acnt, 0);
    check("rw_cfgv",   32'(cfg_valid), 0);
    b_access(1'b1, 19'h06000, 8'hC3, d, lat, we_c, oe_c, stable);
    check("rw2_lat",    lat, WEC + 2);
    check("rw2_we_cyc", we_c, WEC);
    check("rw2_stable", stable, 1);
    tick();
    a_read(19'h06000, d, lat);
    check("rw2_rdata", 32'(d), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
